// File: rtl/io_confirm_ctrl_pkg.sv
// Shared definitions for the minisys IO confirm path: widths and FSM encodings.
package io_confirm_ctrl_pkg;

    localparam int ISA_WIDTH    = 32;
    localparam int SW_WIDTH_DEF = 16;

    // Switch-read handshake states
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        CAPTURE      = 2'd2,
        WAIT_RELEASE = 2'd3
    } io_state_e;

endpackage

// File: rtl/io_confirm_ctrl_btn_debounce.sv
// Confirm-button conditioning: 2-flop synchronizer, stable-level debounce, rise pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise
);

    logic             sync1, sync2;
    logic [CNT_W-1:0] cnt;

    // Two-stage synchronizer for the asynchronous button pin
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples;
    // btn_rise is raised on the same edge the level goes high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
        end else begin
            btn_rise <= 1'b0;
            if (sync2 == btn_level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt       <= '0;
                btn_level <= ~btn_level;
                btn_rise  <= ~btn_level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_confirm_ctrl.sv
// Holds the CPU on a switch read until the confirm button is pressed, then
// captures the switches and releases the CPU for exactly one read.
module io_confirm_ctrl
    import io_confirm_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int SW_WIDTH        = SW_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                io_read_req,
    input  logic [SW_WIDTH-1:0] switches,
    input  logic                comfirm_button,
    output logic                stall,
    output logic [SW_WIDTH-1:0] io_rdata,
    output logic                io_valid,
    output logic                waiting
);

    io_state_e           state, next_state;
    logic [SW_WIDTH-1:0] sw_sync1, sw_sync2;
    logic                btn_level, btn_rise;
    logic                capture;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (comfirm_button),
        .btn_level (btn_level),
        .btn_rise  (btn_rise)
    );

    // Two-stage synchronizer for the asynchronous switch bank
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_sync1 <= '0;
            sw_sync2 <= '0;
        end else begin
            sw_sync1 <= switches;
            sw_sync2 <= sw_sync1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Captured read data; held until the next press is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         io_rdata <= '0;
        else if (capture) io_rdata <= sw_sync2;
    end

    // Next-state and handshake outputs. A withdrawn request beats a
    // simultaneous press, and a button already down at request time must be
    // released first so one press never serves two reads.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        waiting    = 1'b0;
        io_valid   = 1'b0;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                stall = io_read_req;
                if (io_read_req) next_state = btn_level ? WAIT_RELEASE : WAIT_PRESS;
            end
            WAIT_PRESS: begin
                stall   = 1'b1;
                waiting = 1'b1;
                if (!io_read_req) begin
                    next_state = IDLE;
                end else if (btn_rise) begin
                    next_state = CAPTURE;
                    capture    = 1'b1;
                end
            end
            CAPTURE: begin
                io_valid   = 1'b1;
                next_state = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                stall = io_read_req;
                if (!btn_level) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_io_confirm_ctrl.sv
// Directed bench for io_confirm_ctrl with a short debounce window.
module tb_io_confirm_ctrl;

    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req = 1'b0;
    logic          btn = 1'b0;
    logic [SW-1:0] sw  = '0;
    logic          stall, io_valid, waiting;
    logic [SW-1:0] io_rdata;

    int checks = 0;
    int fails  = 0;

    io_confirm_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3),
        .SW_WIDTH        (SW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .io_read_req    (req),
        .switches       (sw),
        .comfirm_button (btn),
        .stall          (stall),
        .io_rdata       (io_rdata),
        .io_valid       (io_valid),
        .waiting        (waiting)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          req;
        logic          btn;
        logic [SW-1:0] sw;
        logic          e_stall;
        logic          e_valid;
        logic          e_wait;
        logic [SW-1:0] e_rdata;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance up to max cycles looking for io_valid; stall must stay high until then.
    task automatic wait_valid(input string name, input int max);
        bit got = 0;
        bit stall_drop = 0;
        for (int i = 0; i < max && !got; i++) begin
            step();
            if (io_valid) got = 1;
            else if (!stall) stall_drop = 1;
        end
        chk({name, "_seen"}, 32'(got), 32'd1);
        chk({name, "_stall_held"}, 32'(stall_drop), 32'd0);
        if (got) chk({name, "_stall_lo"}, 32'(stall), 32'd0);
    endtask

    // Run n cycles; io_valid must never appear.
    task automatic no_valid(input string name, input int n, input logic exp_stall);
        bit seen = 0;
        bit bad_stall = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (io_valid) seen = 1;
            if (stall !== exp_stall) bad_stall = 1;
        end
        chk({name, "_no_valid"}, 32'(seen), 32'd0);
        chk({name, "_stall"}, 32'(bad_stall), 32'd0);
    endtask

    task automatic release_all();
        req = 1'b0;
        btn = 1'b0;
        for (int i = 0; i < 14; i++) step();
    endtask

    initial begin
        // Basic read, cycle by cycle: press seen at debounced level 6 edges after
        // the raw edge, capture on the following edge.
        tbl[0] = '{1'b1, 1'b0, 16'hA5C3, 1'b1, 1'b0, 1'b1, 16'h0000};
        tbl[1] = '{1'b1, 1'b1, 16'hA5C3, 1'b1, 1'b0, 1'b1, 16'h0000};
        tbl[2] = '{1'b1, 1'b1, 16'hA5C3, 1'b1, 1'b0, 1'b1, 16'h0000};
        tbl[3] = '{1'b1, 1'b1, 16'hA5C3, 1'b1, 1'b0, 1'b1, 16'h0000};
        tbl[4] = '{1'b1, 1'b1, 16'hA5C3, 1'b1, 1'b0, 1'b1, 16'h0000};
        tbl[5] = '{1'b1, 1'b1, 16'hA5C3, 1'b1, 1'b0, 1'b1, 16'h0000};
        tbl[6] = '{1'b1, 1'b1, 16'hA5C3, 1'b1, 1'b0, 1'b1, 16'h0000};
        tbl[7] = '{1'b1, 1'b1, 16'hA5C3, 1'b0, 1'b1, 1'b0, 16'hA5C3};
        tbl[8] = '{1'b0, 1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b0, 16'hA5C3};
        tbl[9] = '{1'b0, 1'b0, 16'hA5C3, 1'b0, 1'b0, 1'b0, 16'hA5C3};

        // Reset state
        #12;
        chk("rst_rdata", 32'(io_rdata), 32'h0);
        chk("rst_valid", 32'(io_valid), 32'h0);
        chk("rst_wait", 32'(waiting), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req;
            btn = tbl[i].btn;
            sw  = tbl[i].sw;
            step();
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
            chk($sformatf("vec%0d_valid", i), 32'(io_valid), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d_wait", i), 32'(waiting), 32'(tbl[i].e_wait));
            chk($sformatf("vec%0d_rdata", i), 32'(io_rdata), 32'(tbl[i].e_rdata));
        end
        release_all();

        // Bounce: short toggles never reach the debounce threshold
        req = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            btn = (i % 2 == 0);
            step();
        end
        btn = 1'b0;
        no_valid("bounce", 12, 1'b1);
        chk("bounce_wait", 32'(waiting), 32'd1);
        release_all();

        // Button already held when the request arrives
        btn = 1'b1;
        for (int i = 0; i < 10; i++) step();
        req = 1'b1;
        sw  = 16'h1234;
        step();
        chk("held_wait_lo", 32'(waiting), 32'd0);
        no_valid("held", 10, 1'b1);
        btn = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("held_rel_wait", 32'(waiting), 32'd1);
        sw  = 16'hBEEF;
        btn = 1'b1;
        wait_valid("held_press", 20);
        chk("held_rdata", 32'(io_rdata), 32'hBEEF);
        release_all();

        // Back-to-back reads with the request held high
        sw  = 16'h0001;
        req = 1'b1;
        btn = 1'b1;
        wait_valid("b2b_1", 20);
        chk("b2b_rdata1", 32'(io_rdata), 32'h0001);
        no_valid("b2b_hold", 10, 1'b1);
        sw  = 16'h0002;
        btn = 1'b0;
        no_valid("b2b_rel", 10, 1'b1);
        chk("b2b_rel_wait", 32'(waiting), 32'd1);
        chk("b2b_rdata_kept", 32'(io_rdata), 32'h0001);
        btn = 1'b1;
        wait_valid("b2b_2", 20);
        chk("b2b_rdata2", 32'(io_rdata), 32'h0002);
        release_all();

        // Asynchronous reset while waiting for a press
        req = 1'b1;
        step();
        step();
        chk("mid_wait_pre", 32'(waiting), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_wait", 32'(waiting), 32'd0);
        chk("mid_rst_rdata", 32'(io_rdata), 32'h0);
        chk("mid_rst_valid", 32'(io_valid), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd1);
        step();
        rst = 1'b1;
        step();
        chk("post_rst_wait", 32'(waiting), 32'd1);
        chk("post_rst_stall", 32'(stall), 32'd1);

        // Request withdrawn while waiting; a later press is ignored
        req = 1'b0;
        step();
        chk("wd_wait", 32'(waiting), 32'd0);
        chk("wd_stall", 32'(stall), 32'd0);
        btn = 1'b1;
        no_valid("wd_press", 12, 1'b0);
        release_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=done");
        $fatal(1);
    end

endmodule
